// File: rtl/adc_cfg_pkg.sv
// Shared types and constants for the ADC serial configuration sequencer.
// Command words are {addr[7:0], data[15:0]} and are shifted MSB first.
package adc_cfg_pkg;

    localparam int CMD_W  = 24;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    // Frequently used register writes for the ADC
    localparam logic [CMD_W-1:0] TGC_REG    = 24'h000004;
    localparam logic [CMD_W-1:0] FIXED_GAIN = 24'h990008;
    localparam logic [CMD_W-1:0] GAIN       = 24'h9A0010;
    localparam logic [CMD_W-1:0] RAMP_TEST  = 24'h02E000;
    localparam logic [CMD_W-1:0] SYNC_TEST  = 24'h022000;

    typedef enum logic [2:0] {
        RST_PULSE,
        RST_WAIT,
        READY,
        SETUP,
        SHIFT,
        GAP
    } state_e;

endpackage

// File: rtl/adc_sclk_tick.sv
// Half-period timer for SCLK: emits a one-cycle tick every SCLK_HALF enabled cycles.
// The count restarts whenever clr is high or the timer is disabled.
module adc_sclk_tick #(
    parameter int SCLK_HALF = 5
) (
    input  logic clk_50,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (SCLK_HALF > 2) ? $clog2(SCLK_HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCLK_HALF - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || !en || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/adc_serial_cfg_seq.sv
// ADC reset/power-up sequencer and 24-bit serial register writer (SCLK/SEN/SDATA).
// Define ADC_CFG_READBACK_EN to add SDOUT capture on rd_data/rd_valid.
module adc_serial_cfg_seq
    import adc_cfg_pkg::*;
#(
    parameter int SCLK_HALF         = 5,
    parameter int RESET_CYCLES      = 10,
    parameter int POST_RESET_CYCLES = 100,
    parameter int GAP_HALVES        = 2
) (
    input  logic             clk_50,
    input  logic             rst_n,
    input  logic             init_req,
    input  logic             cmd_valid,
    input  logic [CMD_W-1:0] cmd_data,
    output logic             cmd_ready,
    output logic             cmd_done,
    output logic             busy,
    output logic             init_done,
    input  logic             pdn_req,
    input  logic             sdout,
    output logic             adc_reset,
    output logic             sclk,
    output logic             sen,
    output logic             sdata,
    output logic             pdn
`ifdef ADC_CFG_READBACK_EN
    ,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
`endif
);

    localparam logic [4:0]  LAST_BIT   = 5'(CMD_W);
    localparam logic [4:0]  FIRST_DATA = 5'(ADDR_W);
    localparam logic [15:0] PULSE_LAST = 16'(RESET_CYCLES - 1);
    localparam logic [15:0] WAIT_LAST  = 16'(POST_RESET_CYCLES);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_HALVES - 1);

    state_e             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [4:0]         bit_cnt_q, bit_cnt_d;
    logic [CMD_W-2:0]   shift_q, shift_d;
    logic               init_done_q, init_done_d;
    logic               adc_reset_q, adc_reset_d;
    logic               sclk_q, sclk_d;
    logic               sen_q, sen_d;
    logic               sdata_q, sdata_d;
    logic               pdn_q;
    logic               cmd_done_c;
    logic               tick_en;
    logic               tick_clr;
    logic               tick;
    logic               rise_tick;

    adc_sclk_tick #(
        .SCLK_HALF (SCLK_HALF)
    ) u_tick (
        .clk_50 (clk_50),
        .rst_n  (rst_n),
        .en     (tick_en),
        .clr    (tick_clr),
        .tick   (tick)
    );

    assign tick_en   = (state_q == SETUP) || (state_q == SHIFT) || (state_q == GAP);
    assign tick_clr  = (state_d != state_q);
    assign rise_tick = (state_q == SHIFT) && tick && !sclk_q;

    assign busy      = (state_q != READY);
    assign cmd_ready = (state_q == READY) && !init_req;
    assign cmd_done  = cmd_done_c;
    assign init_done = init_done_q;
    assign adc_reset = adc_reset_q;
    assign sclk      = sclk_q;
    assign sen       = sen_q;
    assign sdata     = sdata_q;
    assign pdn       = pdn_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        init_done_d = init_done_q;
        adc_reset_d = 1'b0;
        sclk_d      = sclk_q;
        sen_d       = sen_q;
        sdata_d     = sdata_q;
        cmd_done_c  = 1'b0;

        case (state_q)
            RST_PULSE: begin
                adc_reset_d = 1'b1;
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == PULSE_LAST) begin
                    state_d = RST_WAIT;
                    cnt_d   = '0;
                end
            end
            // adc_reset drops one edge after entry, so the wait counts one extra cycle
            RST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == WAIT_LAST) begin
                    state_d     = READY;
                    cnt_d       = '0;
                    init_done_d = 1'b1;
                end
            end
            READY: begin
                if (init_req) begin
                    state_d     = RST_PULSE;
                    cnt_d       = '0;
                    init_done_d = 1'b0;
                end else if (cmd_valid) begin
                    state_d   = SETUP;
                    shift_d   = cmd_data[CMD_W-2:0];
                    bit_cnt_d = '0;
                    sclk_d    = 1'b0;
                    sen_d     = 1'b0;
                    sdata_d   = cmd_data[CMD_W-1];
                end
            end
            // SHIFT is entered with sclk low, so the first tick there is a rising edge
            SETUP: begin
                if (tick) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (!sclk_q) begin
                        sclk_d    = 1'b1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end else if (bit_cnt_q == LAST_BIT) begin
                        state_d = GAP;
                        cnt_d   = '0;
                        sclk_d  = 1'b0;
                        sen_d   = 1'b1;
                        sdata_d = 1'b0;
                    end else begin
                        sclk_d  = 1'b0;
                        sdata_d = shift_q[CMD_W-2];
                        shift_d = {shift_q[CMD_W-3:0], 1'b0};
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == GAP_LAST) begin
                        state_d    = READY;
                        cnt_d      = '0;
                        cmd_done_c = 1'b1;
                    end
                end
            end
            default: begin
                state_d = RST_PULSE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST_PULSE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            init_done_q <= 1'b0;
            adc_reset_q <= 1'b0;
            sclk_q      <= 1'b0;
            sen_q       <= 1'b1;
            sdata_q     <= 1'b0;
            pdn_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            init_done_q <= init_done_d;
            adc_reset_q <= adc_reset_d;
            sclk_q      <= sclk_d;
            sen_q       <= sen_d;
            sdata_q     <= sdata_d;
            pdn_q       <= pdn_req;
        end
    end

`ifdef ADC_CFG_READBACK_EN
    logic              sdout_meta_q;
    logic              sdout_sync_q;
    logic [DATA_W-1:0] rd_shift_q, rd_shift_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    // Capture only during the data phase (rising edges 9..24), MSB first
    always_comb begin
        rd_shift_d = rd_shift_q;
        if (rise_tick && (bit_cnt_q >= FIRST_DATA)) begin
            rd_shift_d = {rd_shift_q[DATA_W-2:0], sdout_sync_q};
        end
        rd_data_d = cmd_done_c ? rd_shift_q : rd_data_q;
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            sdout_meta_q <= 1'b0;
            sdout_sync_q <= 1'b0;
            rd_shift_q   <= '0;
            rd_data_q    <= '0;
        end else begin
            sdout_meta_q <= sdout;
            sdout_sync_q <= sdout_meta_q;
            rd_shift_q   <= rd_shift_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign rd_valid = cmd_done_c;
    assign rd_data  = rd_data_d;
`else
    // Readback is compiled out; sdout and the rising-edge strobe have no consumer
    logic sdout_unused;
    logic rise_tick_unused;
    assign sdout_unused     = sdout;
    assign rise_tick_unused = rise_tick;
`endif

endmodule

// File: tb/tb_adc_serial_cfg_seq.sv
// Directed self-checking bench for adc_serial_cfg_seq (default parameters).
// Define ADC_CFG_READBACK_EN to also exercise the SDOUT readback path.
module tb_adc_serial_cfg_seq;
    import adc_cfg_pkg::*;

    logic        clk_50 = 1'b0;
    logic        rst_n;
    logic        init_req;
    logic        cmd_valid;
    logic [23:0] cmd_data;
    logic        cmd_ready;
    logic        cmd_done;
    logic        busy;
    logic        init_done;
    logic        pdn_req;
    logic        sdout;
    logic        adc_reset;
    logic        sclk;
    logic        sen;
    logic        sdata;
    logic        pdn;
`ifdef ADC_CFG_READBACK_EN
    logic [15:0] rd_data;
    logic        rd_valid;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #10 clk_50 = ~clk_50;

    adc_serial_cfg_seq dut (
        .clk_50    (clk_50),
        .rst_n     (rst_n),
        .init_req  (init_req),
        .cmd_valid (cmd_valid),
        .cmd_data  (cmd_data),
        .cmd_ready (cmd_ready),
        .cmd_done  (cmd_done),
        .busy      (busy),
        .init_done (init_done),
        .pdn_req   (pdn_req),
        .sdout     (sdout),
        .adc_reset (adc_reset),
        .sclk      (sclk),
        .sen       (sen),
        .sdata     (sdata),
        .pdn       (pdn)
`ifdef ADC_CFG_READBACK_EN
        ,
        .rd_data   (rd_data),
        .rd_valid  (rd_valid)
`endif
    );

    // Observe a reset sequence one negedge at a time until init_done rises
    task automatic watch_reset_seq(output int rst_first, output int rst_high,
                                   output int done_at, output int sen_bad);
        rst_first = 0;
        rst_high  = 0;
        done_at   = 0;
        sen_bad   = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk_50);
            if (adc_reset) begin
                rst_high++;
                if (rst_first == 0) rst_first = i;
            end
            if (!sen || sclk) sen_bad++;
            if (init_done) begin
                done_at = i;
                break;
            end
        end
    endtask

    // Present a command at a negedge and release cmd_valid just after the accept edge
    task automatic send_cmd(input logic [23:0] w);
        int waited;
        cmd_data  = w;
        cmd_valid = 1'b1;
        waited    = 0;
        while (!cmd_ready && waited < 400) begin
            @(negedge clk_50);
            waited++;
        end
        @(posedge clk_50);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Record one SEN-low frame and the cmd_done pulse that follows it
    task automatic capture_frame(output logic [23:0] word, output int rises,
                                 output int low_cycles, output int pre_wait,
                                 output int gap_to_done, output int done_width);
        logic prev;
        word        = '0;
        rises       = 0;
        low_cycles  = 0;
        pre_wait    = 0;
        gap_to_done = 0;
        done_width  = 0;
        prev        = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_50);
            if (!sen) break;
            pre_wait++;
        end
        while (!sen && low_cycles < 400) begin
            low_cycles++;
            if (sclk && !prev) begin
                word = {word[22:0], sdata};
                rises++;
            end
            prev = sclk;
            @(negedge clk_50);
        end
        for (int i = 1; i <= 40; i++) begin
            if (cmd_done) begin
                gap_to_done = i;
                break;
            end
            @(negedge clk_50);
        end
        while (cmd_done && done_width < 5) begin
            done_width++;
            @(negedge clk_50);
        end
    endtask

    task automatic test_reset();
        int rf, rh, da, sb;
        @(negedge clk_50);
        tests_run++;
        if ({sen, sclk, sdata, adc_reset, pdn} !== 5'b10000) begin
            tests_failed++;
            $display("[TB] FAIL reset_pins: got %05b expected 10000", {sen, sclk, sdata, adc_reset, pdn});
        end
        tests_run++;
        if ({cmd_ready, cmd_done, busy, init_done} !== 4'b0010) begin
            tests_failed++;
            $display("[TB] FAIL reset_status: got %04b expected 0010", {cmd_ready, cmd_done, busy, init_done});
        end
        rst_n = 1'b1;
        watch_reset_seq(rf, rh, da, sb);
        tests_run++;
        if (rf !== 1) begin
            tests_failed++;
            $display("[TB] FAIL por_reset_rise: got %0d expected 1", rf);
        end
        tests_run++;
        if (rh !== 10) begin
            tests_failed++;
            $display("[TB] FAIL por_reset_width: got %0d expected 10", rh);
        end
        tests_run++;
        if (da - rf !== 110) begin
            tests_failed++;
            $display("[TB] FAIL por_init_done_delay: got %0d expected 110", da - rf);
        end
        tests_run++;
        if ({cmd_ready, busy, sb != 0} !== 3'b100) begin
            tests_failed++;
            $display("[TB] FAIL por_ready: got ready=%0b busy=%0b sen_bad=%0d expected 1 0 0", cmd_ready, busy, sb);
        end
    endtask

    task automatic test_single_cmd();
        logic [23:0] w;
        int r, lc, pw, gd, dw;
        send_cmd(GAIN);
        capture_frame(w, r, lc, pw, gd, dw);
        tests_run++;
        if (w !== 24'h9A0010) begin
            tests_failed++;
            $display("[TB] FAIL single_word: got %06h expected 9a0010", w);
        end
        tests_run++;
        if (r !== 24) begin
            tests_failed++;
            $display("[TB] FAIL single_rises: got %0d expected 24", r);
        end
        tests_run++;
        if (lc !== 245) begin
            tests_failed++;
            $display("[TB] FAIL single_sen_low: got %0d expected 245", lc);
        end
        tests_run++;
        if (gd !== 10 || dw !== 1) begin
            tests_failed++;
            $display("[TB] FAIL single_done: got gap=%0d width=%0d expected 10 1", gd, dw);
        end
        tests_run++;
        if ({cmd_ready, busy, sen, sclk, sdata} !== 5'b10100) begin
            tests_failed++;
            $display("[TB] FAIL single_idle: got %05b expected 10100", {cmd_ready, busy, sen, sclk, sdata});
        end
    endtask

    task automatic test_pdn();
        pdn_req = 1'b1;
        #1;
        tests_run++;
        if (pdn !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL pdn_latency: got %0b expected 0", pdn);
        end
        @(negedge clk_50);
        tests_run++;
        if (pdn !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL pdn_high: got %0b expected 1", pdn);
        end
        pdn_req = 1'b0;
        @(negedge clk_50);
        tests_run++;
        if (pdn !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL pdn_low: got %0b expected 0", pdn);
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] w1, w2;
        int r1, lc1, pw1, gd1, dw1;
        int r2, lc2, pw2, gd2, dw2;
        int guard;
        cmd_data  = FIXED_GAIN;
        cmd_valid = 1'b1;
        guard     = 0;
        while (!cmd_ready && guard < 50) begin
            @(negedge clk_50);
            guard++;
        end
        @(posedge clk_50);
        #1;
        cmd_data = TGC_REG;
        capture_frame(w1, r1, lc1, pw1, gd1, dw1);
        tests_run++;
        if ({sen, cmd_ready, dw1 == 1} !== 3'b111) begin
            tests_failed++;
            $display("[TB] FAIL b2b_held_until_done: got sen=%0b ready=%0b width=%0d expected 1 1 1", sen, cmd_ready, dw1);
        end
        @(posedge clk_50);
        #1;
        cmd_valid = 1'b0;
        capture_frame(w2, r2, lc2, pw2, gd2, dw2);
        tests_run++;
        if (w1 !== 24'h990008) begin
            tests_failed++;
            $display("[TB] FAIL b2b_word1: got %06h expected 990008", w1);
        end
        tests_run++;
        if (w2 !== 24'h000004 || r2 !== 24) begin
            tests_failed++;
            $display("[TB] FAIL b2b_word2: got %06h rises=%0d expected 000004 24", w2, r2);
        end
        tests_run++;
        if (gd1 + 1 + pw2 < 10) begin
            tests_failed++;
            $display("[TB] FAIL b2b_sen_gap: got %0d expected at least 10", gd1 + 1 + pw2);
        end
    endtask

    task automatic test_init_priority();
        logic [23:0] w;
        int rf, rh, da, sb;
        int r, lc, pw, gd, dw;
        init_req  = 1'b1;
        cmd_valid = 1'b1;
        cmd_data  = SYNC_TEST;
        #1;
        tests_run++;
        if (cmd_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL init_blocks_ready: got %0b expected 0", cmd_ready);
        end
        @(posedge clk_50);
        #1;
        init_req = 1'b0;
        tests_run++;
        if ({init_done, busy} !== 2'b01) begin
            tests_failed++;
            $display("[TB] FAIL init_clears_done: got done=%0b busy=%0b expected 0 1", init_done, busy);
        end
        watch_reset_seq(rf, rh, da, sb);
        tests_run++;
        if (rf !== 2 || rh !== 10) begin
            tests_failed++;
            $display("[TB] FAIL init_reset_pulse: got rise=%0d width=%0d expected 2 10", rf, rh);
        end
        tests_run++;
        if (da - rf !== 110 || sb !== 0) begin
            tests_failed++;
            $display("[TB] FAIL init_no_accept: got delay=%0d sen_bad=%0d expected 110 0", da - rf, sb);
        end
        @(posedge clk_50);
        #1;
        cmd_valid = 1'b0;
        capture_frame(w, r, lc, pw, gd, dw);
        tests_run++;
        if (w !== 24'h022000 || pw !== 0) begin
            tests_failed++;
            $display("[TB] FAIL init_then_accept: got %06h wait=%0d expected 022000 0", w, pw);
        end
    endtask

`ifdef ADC_CFG_READBACK_EN
    task automatic test_readback();
        logic [15:0] rb;
        logic        prev;
        int          rises;
        int          seen;
        rb    = 16'hA5C3;
        prev  = 1'b0;
        rises = 0;
        seen  = 0;
        sdout = 1'b0;
        send_cmd(FIXED_GAIN);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_50);
            if (sclk && !prev) rises++;
            if (!sclk && prev) sdout = (rises >= 8 && rises <= 23) ? rb[23 - rises] : 1'b0;
            prev = sclk;
            if (cmd_done) begin
                seen = 1;
                break;
            end
        end
        tests_run++;
        if (seen !== 1 || rd_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL rb_valid: got seen=%0d rd_valid=%0b expected 1 1", seen, rd_valid);
        end
        tests_run++;
        if (rd_data !== 16'hA5C3) begin
            tests_failed++;
            $display("[TB] FAIL rb_data: got %04h expected a5c3", rd_data);
        end
        sdout = 1'b0;
        @(negedge clk_50);
        tests_run++;
        if (rd_valid !== 1'b0 || rd_data !== 16'hA5C3) begin
            tests_failed++;
            $display("[TB] FAIL rb_hold: got valid=%0b data=%04h expected 0 a5c3", rd_valid, rd_data);
        end
    endtask
`endif

    task automatic test_reset_mid_shift();
        int   rises;
        int   sclk_seen;
        int   rf, rh, da, sb;
        logic prev;
        pdn_req = 1'b1;
        send_cmd(24'h12F0F0);
        rises = 0;
        prev  = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_50);
            if (sclk && !prev) rises++;
            prev = sclk;
            if (rises == 12) break;
        end
        tests_run++;
        if (rises !== 12 || sdata !== 1'b1 || sen !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midshift_pre: got rises=%0d sdata=%0b sen=%0b expected 12 1 0", rises, sdata, sen);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({sen, sclk, sdata, adc_reset} !== 4'b1000) begin
            tests_failed++;
            $display("[TB] FAIL midshift_abort_pins: got %04b expected 1000", {sen, sclk, sdata, adc_reset});
        end
        tests_run++;
        if ({busy, cmd_ready, init_done, pdn} !== 4'b1000) begin
            tests_failed++;
            $display("[TB] FAIL midshift_abort_status: got %04b expected 1000", {busy, cmd_ready, init_done, pdn});
        end
        sclk_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_50);
            if (sclk || !sen) sclk_seen++;
        end
        tests_run++;
        if (sclk_seen !== 0) begin
            tests_failed++;
            $display("[TB] FAIL midshift_no_sclk: got %0d expected 0", sclk_seen);
        end
        rst_n = 1'b1;
        watch_reset_seq(rf, rh, da, sb);
        tests_run++;
        if (rf !== 1 || rh !== 10 || da - rf !== 110) begin
            tests_failed++;
            $display("[TB] FAIL midshift_replay: got rise=%0d width=%0d delay=%0d expected 1 10 110", rf, rh, da - rf);
        end
        tests_run++;
        if (pdn !== 1'b1 || cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midshift_after: got pdn=%0b ready=%0b expected 1 1", pdn, cmd_ready);
        end
        pdn_req = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        init_req  = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        pdn_req   = 1'b0;
        sdout     = 1'b0;
        repeat (3) @(negedge clk_50);
        test_reset();
        test_single_cmd();
        test_pdn();
        test_back_to_back();
        test_init_priority();
`ifdef ADC_CFG_READBACK_EN
        test_readback();
`endif
        test_reset_mid_shift();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
